// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and width legality check shared by the serial subtractor.
`define SERIAL_SUB_W_OK(w) (((w) >= 2) && ((w) <= 32))

package serial_subtractor_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_full_sub.sv
// full_sub: gate-level full-subtractor cell, d = a - b - bin with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic t, na, nt, g1, g2;

    xor x1 (t, a, b);
    xor x2 (d, t, bin);
    not n1 (na, a);
    and a1 (g1, na, b);
    not n2 (nt, t);
    and a2 (g2, nt, bin);
    or  o1 (bout, g1, g2);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor, diff = a - b LSB first, one bit per clock.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);
    localparam int CW = $clog2(W);

    if (!`SERIAL_SUB_W_OK(W)) begin : g_bad_w
        $error("serial_subtractor: W must be in 2..32");
    end

    state_t          state, state_n;
    logic [W-1:0]    sa, sb;
    logic [CW-1:0]   cnt;
    logic            borrow, d, bo, last;

    full_sub u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bo)
    );

    always_comb begin
        last    = cnt == CW'(W - 1);
        state_n = (state == S_IDLE && start) ? S_SHIFT :
                  (state == S_SHIFT && last) ? S_DONE  :
                  (state == S_DONE)          ? S_IDLE  : state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n == S_SHIFT;
            done  <= state_n == S_DONE;
        end
    end

    // Result bits fill the minuend register from the top as its bits are consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            sa     <= a;
            sb     <= b;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == S_SHIFT) begin
            sa     <= {d, sa[W-1:1]};
            sb     <= sb >> 1;
            cnt    <= last ? '0 : cnt + CW'(1);
            borrow <= bo;
            if (last) begin
                diff <= {d, sa[W-1:1]};
                bout <= bo;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard-driven bench for the bit-serial subtractor at W=8.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Call at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold, input string name);
        exp_t e;
        int   bc = 0;
        bit   seen = 0;
        a = x;
        b = y;
        start = 1'b1;
        sb_q.push_back({x - y, x < y});
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < W + 4 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: done never seen within %0d cycles", name, W + 4);
        end
        n_checks++;
        if (bc !== W) begin
            n_fail++;
            $display("FAIL %s busy width: got %0d want %0d", name, bc, W);
        end
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            n_checks++;
            if (diff !== e.d || bout !== e.bo) begin
                n_fail++;
                $display("FAIL %s result: got diff=%h bout=%b want diff=%h bout=%b", name, diff, bout, e.d, e.bo);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse: got done=%b busy=%b want 0/0 after done", name, done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b want 0", busy, done, diff, bout);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(8'h05, 8'h03, 0, "5-3");
        run_op(8'h03, 8'h05, 0, "3-5");
        repeat (3) @(negedge clk);
        n_checks++;
        if (diff !== 8'hFE || bout !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got diff=%h bout=%b done=%b want FE/1/0", diff, bout, done);
        end
    endtask

    task automatic test_edges();
        run_op(8'h00, 8'h01, 0, "0-1");
        run_op(8'hFF, 8'hFF, 0, "FF-FF");
        run_op(8'h80, 8'h7F, 0, "80-7F");
    endtask

    task automatic test_busy_start();
        int   nd = 0;
        exp_t e;
        logic [W-1:0] got = '0;
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        sb_q.push_back({8'h0F, 1'b0});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                got = diff;
            end
        end
        e = sb_q.pop_front();
        n_checks++;
        if (nd !== 1) begin
            n_fail++;
            $display("FAIL busy_start done count: got %0d want 1", nd);
        end
        n_checks++;
        if (got !== e.d) begin
            n_fail++;
            $display("FAIL busy_start diff: got %h want %h", got, e.d);
        end
        run_op(8'h21, 8'h01, 1, "hold_in_done");
        run_op(8'h07, 8'h02, 0, "resample");
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b want 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd !== 0) begin
            n_fail++;
            $display("FAIL reset_mid spurious done: got %0d want 0", nd);
        end
        run_op(8'h09, 8'h04, 0, "9-4");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1, "random");
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
